// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel word as start/data/parity/stop.
// It drives an external serializer (load, ser_en), carries the serializer's
// bits onto the line, and flags serializer protocol errors.
//
// Ports:
//   clk, rst      - system clock, asynchronous active-high reset
//   p_data        - word to send, captured when data_valid is seen
//   data_valid    - send request, sampled in IDLE and in STOP
//   par_en        - 1 appends a parity bit
//   par_typ       - 0 selects even parity, 1 selects odd parity
//   ser_data      - current bit from the serializer
//   ser_done      - serializer last-bit indication
//   ser_p_data    - held word presented to the serializer
//   load          - serializer capture strobe (START)
//   ser_en        - serializer shift enable (START and DATA)
//   tx_out        - UART line, idles high
//   busy          - frame in progress
//   ser_err       - sticky serializer protocol error
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  load,
    output logic                  ser_en,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  ser_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic             par_en_q;
    logic             parity_q;
    logic             parity_in;
    logic             cnt_last;
    logic             proto_bad;

    // Parity of the word being captured; odd parity is the inverted XOR.
    assign parity_in = (^p_data) ^ par_typ;
    assign cnt_last  = (bit_cnt == LAST);
    // ser_done must rise exactly on the last data bit.
    assign proto_bad = cnt_last ? ~ser_done : ser_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ser_p_data <= '0;
            par_en_q   <= 1'b0;
            parity_q   <= 1'b0;
            bit_cnt    <= '0;
            ser_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, STOP: begin
                    if (data_valid) begin
                        ser_p_data <= p_data;
                        par_en_q   <= par_en;
                        parity_q   <= parity_in;
                        state      <= START;
                    end else begin
                        state      <= IDLE;
                    end
                end
                START: begin
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (proto_bad)
                        ser_err <= 1'b1;
                    // Exit is counted, never taken from ser_done.
                    if (cnt_last) begin
                        bit_cnt <= '0;
                        state   <= par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: state <= STOP;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tx_out = 1'b1;
        load   = 1'b0;
        ser_en = 1'b0;
        busy   = 1'b1;
        case (state)
            START: begin
                tx_out = 1'b0;
                load   = 1'b1;
                ser_en = 1'b1;
            end
            DATA: begin
                tx_out = ser_data;
                ser_en = 1'b1;
            end
            PARITY: tx_out = parity_q;
            STOP:   tx_out = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a behavioural serializer and a
// frame-level reference model (start, LSB-first data, optional parity, stop).
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
    logic          ser_data;
    logic          ser_done;
    logic [DW-1:0] ser_p_data;
    logic          load;
    logic          ser_en;
    logic          tx_out;
    logic          busy;
    logic          ser_err;

    int n_chk  = 0;
    int n_pass = 0;
    logic early = 1'b0;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_p_data (ser_p_data),
        .load       (load),
        .ser_en     (ser_en),
        .tx_out     (tx_out),
        .busy       (busy),
        .ser_err    (ser_err)
    );

    always #5 clk = ~clk;

    // Serializer model: captures on load, shifts LSB first while enabled.
    logic [DW-1:0] sr;
    int            s_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            s_cnt <= 0;
        end else if (load) begin
            sr    <= ser_p_data;
            s_cnt <= 0;
        end else if (ser_en) begin
            sr    <= sr >> 1;
            s_cnt <= s_cnt + 1;
        end
    end
    assign ser_data = sr[0];
    assign ser_done = ser_en && !load &&
                      (s_cnt == (early ? DW - 2 : DW - 1));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic start_frame(input logic [DW-1:0] d, input logic pe,
                               input logic pt);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
    endtask

    // Checks one whole frame cycle by cycle. Inputs are scrambled during the
    // frame; in STOP the next request (if chained) is presented.
    task automatic frame_check(input logic [DW-1:0] d, input logic pe,
                               input logic pt, input logic chain,
                               input logic [DW-1:0] nd, input logic npe,
                               input logic npt);
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < DW; i++)
            q.push_back(d[i]);
        if (pe)
            q.push_back(($countones(d) % 2 == 1) ^ pt);
        q.push_back(1'b1);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            chk($sformatf("tx[%0d]", k), 32'(tx_out), 32'(q[k]));
            chk($sformatf("busy[%0d]", k), 32'(busy), 32'd1);
            chk($sformatf("ser_en[%0d]", k), 32'(ser_en),
                32'(k <= DW));
            chk($sformatf("load[%0d]", k), 32'(load), 32'(k == 0));
            if (k == q.size() - 1) begin
                p_data     = nd;
                par_en     = npe;
                par_typ    = npt;
                data_valid = chain;
            end else begin
                p_data     = DW'($urandom);
                par_en     = 1'($urandom);
                par_typ    = 1'($urandom);
                data_valid = 1'($urandom);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_tx"}, 32'(tx_out), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d, nd;
        logic          pe, pt, npe, npt, chain;

        rst = 1'b1; p_data = '0; data_valid = 1'b0;
        par_en = 1'b0; par_typ = 1'b0;
        #12;
        chk("rst_tx", 32'(tx_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_ser_en", 32'(ser_en), 32'd0);
        chk("rst_err", 32'(ser_err), 32'd0);
        chk("rst_pdata", 32'(ser_p_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_idle("idle0");

        // 0x9B no parity, then even and odd parity.
        start_frame(8'h9B, 1'b0, 1'b0);
        frame_check(8'h9B, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_idle("f9b");
        start_frame(8'h9B, 1'b1, 1'b0);
        frame_check(8'h9B, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_idle("f9b_even");
        start_frame(8'h9B, 1'b1, 1'b1);
        frame_check(8'h9B, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_idle("f9b_odd");
        chk("err_after_9b", 32'(ser_err), 32'd0);

        // Back-to-back 0x55 then 0xA3.
        start_frame(8'h55, 1'b0, 1'b0);
        frame_check(8'h55, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0);
        frame_check(8'hA3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_idle("b2b");

        // Random frames, randomly chained.
        d = DW'($urandom); pe = 1'($urandom); pt = 1'($urandom);
        start_frame(d, pe, pt);
        for (int i = 0; i < 24; i++) begin
            nd = DW'($urandom); npe = 1'($urandom); npt = 1'($urandom);
            chain = (i != 23) && 1'($urandom);
            frame_check(d, pe, pt, chain, nd, npe, npt);
            if (!chain) begin
                check_idle("rnd");
                if (i != 23)
                    start_frame(nd, npe, npt);
            end
            d = nd; pe = npe; pt = npt;
        end
        chk("err_after_rnd", 32'(ser_err), 32'd0);

        // Reset pulse in the middle of DATA.
        start_frame(8'hC6, 1'b1, 1'b0);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx_out), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ser_en", 32'(ser_en), 32'd0);
        chk("mid_rst_pdata", 32'(ser_p_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_idle("post_rst");
        check_idle("post_rst2");
        start_frame(8'h3C, 1'b1, 1'b1);
        frame_check(8'h3C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_idle("after_rst_frame");
        chk("err_after_rst", 32'(ser_err), 32'd0);

        // Serializer raises ser_done one cycle early.
        early = 1'b1;
        start_frame(8'h9B, 1'b0, 1'b0);
        frame_check(8'h9B, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_idle("early");
        chk("early_err", 32'(ser_err), 32'd1);
        repeat (4) @(negedge clk);
        chk("early_err_sticky", 32'(ser_err), 32'd1);
        early = 1'b0;
        rst = 1'b1;
        #1;
        chk("err_cleared", 32'(ser_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_idle("end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
